// File: rtl/key_lut_cam.sv
// key_lut_cam: runtime-writable key/data CAM with a valid/ready lookup and a 1-cycle registered response.
// Optional hit/miss statistics counters are compiled in when KEY_LUT_CAM_STATS_EN is defined.
module key_lut_cam #(
  parameter int unsigned NR_KEY   = 4,
  parameter int unsigned KEY_LEN  = 8,
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned IDX_LEN  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                inv_en,
  input  logic [KEY_LEN-1:0]  inv_key,
  input  logic [DATA_LEN-1:0] default_out,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [KEY_LEN-1:0]  req_key,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_hit,
  output logic [DATA_LEN-1:0] rsp_data,
  output logic [IDX_LEN-1:0]  rsp_idx,
`ifdef KEY_LUT_CAM_STATS_EN
  input  logic                stats_clr,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt,
`endif
  output logic [IDX_LEN:0]    count
);

  localparam int unsigned CNT_LEN = IDX_LEN + 1;

  logic [NR_KEY-1:0]   valid_q, valid_d;
  logic [KEY_LEN-1:0]  key_q  [NR_KEY];
  logic [KEY_LEN-1:0]  key_d  [NR_KEY];
  logic [DATA_LEN-1:0] data_q [NR_KEY];
  logic [DATA_LEN-1:0] data_d [NR_KEY];
  logic [IDX_LEN-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_LEN-1:0]  count_q, count_d;

  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_hit_q, rsp_hit_d;
  logic [DATA_LEN-1:0] rsp_data_q, rsp_data_d;
  logic [IDX_LEN-1:0]  rsp_idx_q, rsp_idx_d;

  logic                req_fire;
  logic                lu_hit;
  logic [IDX_LEN-1:0]  lu_idx;
  logic [DATA_LEN-1:0] lu_data;
  logic                wr_hit;
  logic [IDX_LEN-1:0]  wr_idx;
  logic                free_any;
  logic [IDX_LEN-1:0]  free_idx;
  logic [NR_KEY-1:0]   inv_match;
  logic                inv_blocked;

  assign req_ready = !rsp_valid_q || rsp_ready;
  assign req_fire  = req_valid && req_ready;

  // Parallel match of lookup, write and invalidate keys against pre-update contents.
  always_comb begin
    lu_hit    = 1'b0;
    lu_idx    = '0;
    lu_data   = '0;
    wr_hit    = 1'b0;
    wr_idx    = '0;
    inv_match = '0;
    for (int unsigned i = 0; i < NR_KEY; i++) begin
      if (valid_q[i] && (key_q[i] == req_key)) begin
        lu_hit  = 1'b1;
        lu_idx  = IDX_LEN'(i);
        lu_data = data_q[i];
      end
      if (valid_q[i] && (key_q[i] == wr_key)) begin
        wr_hit = 1'b1;
        wr_idx = IDX_LEN'(i);
      end
      inv_match[i] = valid_q[i] && (key_q[i] == inv_key);
    end
  end

  // Lowest-index free slot, judged on pre-update valid bits so a same-cycle invalidate is never reused.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = int'(NR_KEY) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IDX_LEN'(i);
      end
    end
  end

  // Table update: invalidate first, then write (hit-update, allocate, or round-robin replace).
  always_comb begin
    valid_d     = valid_q;
    key_d       = key_q;
    data_d      = data_q;
    rr_ptr_d    = rr_ptr_q;
    inv_blocked = wr_en && (inv_key == wr_key);
    if (inv_en && !inv_blocked) begin
      valid_d = valid_q & ~inv_match;
    end
    if (wr_en) begin
      if (wr_hit) begin
        data_d[wr_idx] = wr_data;
      end else if (free_any) begin
        valid_d[free_idx] = 1'b1;
        key_d[free_idx]   = wr_key;
        data_d[free_idx]  = wr_data;
      end else begin
        valid_d[rr_ptr_q] = 1'b1;
        key_d[rr_ptr_q]   = wr_key;
        data_d[rr_ptr_q]  = wr_data;
        rr_ptr_d = (rr_ptr_q == IDX_LEN'(NR_KEY - 1)) ? '0 : rr_ptr_q + IDX_LEN'(1);
      end
    end
    if (rst) begin
      valid_d  = '0;
      rr_ptr_d = '0;
    end
  end

  // Count is the population of the next valid vector, so it can never drift or wrap.
  always_comb begin
    count_d = '0;
    for (int unsigned i = 0; i < NR_KEY; i++) begin
      count_d = count_d + CNT_LEN'(valid_d[i]);
    end
  end

  // Response register: load on fire, drop on consumer handshake, otherwise hold.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_data_d  = rsp_data_q;
    rsp_idx_d   = rsp_idx_q;
    if (req_fire) begin
      rsp_valid_d = 1'b1;
      rsp_hit_d   = lu_hit;
      rsp_data_d  = lu_hit ? lu_data : default_out;
      rsp_idx_d   = lu_hit ? lu_idx : '0;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    if (rst) begin
      rsp_valid_d = 1'b0;
      rsp_hit_d   = 1'b0;
      rsp_data_d  = '0;
      rsp_idx_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    valid_q     <= valid_d;
    rr_ptr_q    <= rr_ptr_d;
    count_q     <= count_d;
    rsp_valid_q <= rsp_valid_d;
    rsp_hit_q   <= rsp_hit_d;
    rsp_data_q  <= rsp_data_d;
    rsp_idx_q   <= rsp_idx_d;
  end

  // Key/data storage carries no reset; valid bits alone qualify it.
  always_ff @(posedge clk) begin
    key_q  <= key_d;
    data_q <= data_d;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_idx   = rsp_idx_q;
  assign count     = count_q;

`ifdef KEY_LUT_CAM_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Outcome counters; clear beats a same-cycle increment.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (req_fire) begin
      if (lu_hit) hit_cnt_d  = hit_cnt_q + 32'd1;
      else        miss_cnt_d = miss_cnt_q + 32'd1;
    end
    if (rst || stats_clr) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    hit_cnt_q  <= hit_cnt_d;
    miss_cnt_q <= miss_cnt_d;
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_key_lut_cam.sv
// Directed self-checking bench for key_lut_cam; stats checks compile in with KEY_LUT_CAM_STATS_EN.
module tb_key_lut_cam;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_key;
  logic [31:0] wr_data;
  logic        inv_en;
  logic [7:0]  inv_key;
  logic [31:0] default_out;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_key;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_hit;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_idx;
  logic [2:0]  count;
`ifdef KEY_LUT_CAM_STATS_EN
  logic        stats_clr;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int errors = 0;
  int checks = 0;

  key_lut_cam dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_key(wr_key), .wr_data(wr_data),
    .inv_en(inv_en), .inv_key(inv_key),
    .default_out(default_out),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hit(rsp_hit), .rsp_data(rsp_data), .rsp_idx(rsp_idx),
`ifdef KEY_LUT_CAM_STATS_EN
    .stats_clr(stats_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] k, input logic [31:0] d);
    wr_en = 1'b1; wr_key = k; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_inv(input logic [7:0] k);
    inv_en = 1'b1; inv_key = k;
    tick();
    inv_en = 1'b0;
  endtask

  task automatic do_lookup(input logic [7:0] k);
    req_valid = 1'b1; req_key = k;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (rsp_data !== 32'h0 || rsp_hit !== 1'b0 || rsp_idx !== 2'd0) begin
      errors++; $display("FAIL reset_rsp_fields: got hit=%b data=%h idx=%0d want 0/0/0", rsp_hit, rsp_data, rsp_idx); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    rst = 1'b0;
  endtask

  task automatic test_fill_hit();
    do_write(8'h11, 32'hA);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL fill_count1: got %0d want 1", count); end
    do_write(8'h22, 32'hB);
    do_write(8'h33, 32'hC);
    do_write(8'h44, 32'hD);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count4: got %0d want 4", count); end
    do_lookup(8'h33);
    checks++; if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1) begin
      errors++; $display("FAIL fill_hit_flags: got valid=%b hit=%b want 1/1", rsp_valid, rsp_hit); end
    checks++; if (rsp_data !== 32'hC || rsp_idx !== 2'd2) begin
      errors++; $display("FAIL fill_hit_data: got data=%h idx=%0d want c/2", rsp_data, rsp_idx); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL fill_rsp_drop: got %b want 0", rsp_valid); end
  endtask

  task automatic test_miss_default();
    default_out = 32'hDEAD;
    do_lookup(8'h55);
    default_out = 32'hBEEF;
    checks++; if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0) begin
      errors++; $display("FAIL miss_flags: got valid=%b hit=%b want 1/0", rsp_valid, rsp_hit); end
    checks++; if (rsp_data !== 32'hDEAD || rsp_idx !== 2'd0) begin
      errors++; $display("FAIL miss_data: got data=%h idx=%0d want dead/0", rsp_data, rsp_idx); end
    tick();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_key = 8'h22;
    tick();
    req_key = 8'h44;
    for (int c = 0; c < 3; c++) begin
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready c%0d: got %b want 0", c, req_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hB || rsp_idx !== 2'd1) begin
        errors++; $display("FAIL bp_hold c%0d: got valid=%b data=%h idx=%0d want 1/b/1", c, rsp_valid, rsp_data, rsp_idx); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_pass: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hD || rsp_idx !== 2'd3) begin
      errors++; $display("FAIL bp_second: got valid=%b data=%h idx=%0d want 1/d/3", rsp_valid, rsp_data, rsp_idx); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", rsp_valid); end
  endtask

  task automatic test_same_cycle();
    inv_en = 1'b1; inv_key = 8'h22;
    wr_en = 1'b1; wr_key = 8'h22; wr_data = 32'h9;
    req_valid = 1'b1; req_key = 8'h22;
    tick();
    inv_en = 1'b0; wr_en = 1'b0; req_valid = 1'b0;
    checks++; if (rsp_hit !== 1'b1 || rsp_data !== 32'hB) begin
      errors++; $display("FAIL same_old_data: got hit=%b data=%h want 1/b", rsp_hit, rsp_data); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL same_count: got %0d want 4", count); end
    do_lookup(8'h22);
    checks++; if (rsp_hit !== 1'b1 || rsp_data !== 32'h9 || rsp_idx !== 2'd1) begin
      errors++; $display("FAIL same_new_data: got hit=%b data=%h idx=%0d want 1/9/1", rsp_hit, rsp_data, rsp_idx); end
    tick();
  endtask

  task automatic test_full_replace();
    do_write(8'h55, 32'hE);
    do_write(8'h66, 32'hF);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL repl_count: got %0d want 4", count); end
    do_lookup(8'h11);
    checks++; if (rsp_hit !== 1'b0 || rsp_data !== 32'hBEEF) begin
      errors++; $display("FAIL repl_evicted: got hit=%b data=%h want 0/beef", rsp_hit, rsp_data); end
    do_lookup(8'h66);
    checks++; if (rsp_hit !== 1'b1 || rsp_data !== 32'hF || rsp_idx !== 2'd1) begin
      errors++; $display("FAIL repl_new: got hit=%b data=%h idx=%0d want 1/f/1", rsp_hit, rsp_data, rsp_idx); end
    do_lookup(8'h55);
    checks++; if (rsp_hit !== 1'b1 || rsp_data !== 32'hE || rsp_idx !== 2'd0) begin
      errors++; $display("FAIL repl_slot0: got hit=%b data=%h idx=%0d want 1/e/0", rsp_hit, rsp_data, rsp_idx); end
    tick();
  endtask

  task automatic test_invalidate();
    do_inv(8'h33);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL inv_count: got %0d want 3", count); end
    do_inv(8'h99);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL inv_miss_count: got %0d want 3", count); end
    do_lookup(8'h33);
    checks++; if (rsp_hit !== 1'b0) begin errors++; $display("FAIL inv_lookup: got hit=%b want 0", rsp_hit); end
    do_write(8'h77, 32'h7);
    do_lookup(8'h77);
    checks++; if (rsp_hit !== 1'b1 || rsp_idx !== 2'd2 || count !== 3'd4) begin
      errors++; $display("FAIL inv_realloc: got hit=%b idx=%0d count=%0d want 1/2/4", rsp_hit, rsp_idx, count); end
    // full table: freed slot 3 must not be reused; replacement lands on rr slot 2
    inv_en = 1'b1; inv_key = 8'h44;
    wr_en = 1'b1; wr_key = 8'h88; wr_data = 32'h8;
    tick();
    inv_en = 1'b0; wr_en = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL inv_wr_count: got %0d want 3", count); end
    do_lookup(8'h88);
    checks++; if (rsp_hit !== 1'b1 || rsp_idx !== 2'd2 || rsp_data !== 32'h8) begin
      errors++; $display("FAIL inv_wr_slot: got hit=%b idx=%0d data=%h want 1/2/8", rsp_hit, rsp_idx, rsp_data); end
    do_lookup(8'h44);
    checks++; if (rsp_hit !== 1'b0) begin errors++; $display("FAIL inv_wr_gone: got hit=%b want 0", rsp_hit); end
    tick();
  endtask

`ifdef KEY_LUT_CAM_STATS_EN
  task automatic test_stats();
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    do_lookup(8'h55);
    do_lookup(8'h11);
    do_lookup(8'h66);
    do_lookup(8'h44);
    do_lookup(8'h88);
    checks++; if (hit_cnt !== 32'd3 || miss_cnt !== 32'd2) begin
      errors++; $display("FAIL stats_counts: got hit=%0d miss=%0d want 3/2", hit_cnt, miss_cnt); end
    stats_clr = 1'b1;
    do_lookup(8'h55);
    stats_clr = 1'b0;
    checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      errors++; $display("FAIL stats_clr: got hit=%0d miss=%0d want 0/0", hit_cnt, miss_cnt); end
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    do_lookup(8'h55);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b want 1", rsp_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    checks++; if (rsp_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL mid_reset: got valid=%b count=%0d want 0/0", rsp_valid, count); end
    do_lookup(8'h55);
    checks++; if (rsp_hit !== 1'b0) begin errors++; $display("FAIL mid_cleared: got hit=%b want 0", rsp_hit); end
`ifdef KEY_LUT_CAM_STATS_EN
    checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd1) begin
      errors++; $display("FAIL mid_stats: got hit=%0d miss=%0d want 0/1", hit_cnt, miss_cnt); end
`endif
    tick();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_key = '0; wr_data = '0;
    inv_en = 1'b0; inv_key = '0; default_out = '0;
    req_valid = 1'b0; req_key = '0; rsp_ready = 1'b1;
`ifdef KEY_LUT_CAM_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_fill_hit();
    test_miss_default();
    test_back_to_back();
    test_same_cycle();
    test_full_replace();
    test_invalidate();
`ifdef KEY_LUT_CAM_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
